// File: rtl/nmea_rmc_capture_if.sv
// Bus between the GPS byte stream / readout side and the RMC capture controller.
// The slave modport is the controller; the master modport is the side that feeds it.
interface nmea_rmc_capture_if #(
    parameter int AW = 6
);
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rd_lock;
    logic        buf_we;
    logic [AW:0] buf_waddr;
    logic [7:0]  buf_wdata;
    logic        rd_bank;
    logic        frame_valid;
    logic [AW:0] frame_len;
    logic        cksum_err;
    logic        ovf_err;

    modport master (
        output rx_data, rx_valid, rd_lock,
        input  buf_we, buf_waddr, buf_wdata, rd_bank, frame_valid, frame_len,
        input  cksum_err, ovf_err
    );

    modport slave (
        input  rx_data, rx_valid, rd_lock,
        output buf_we, buf_waddr, buf_wdata, rd_bank, frame_valid, frame_len,
        output cksum_err, ovf_err
    );
endinterface

// File: rtl/nmea_rmc_capture_ctrl.sv
// Write-side controller and bank arbiter for a double-banked $GPRMC sentence buffer:
// hunts '$', matches the header, stores the sentence, checks the XOR checksum and swaps banks.
module nmea_rmc_capture_ctrl #(
    parameter int BUF_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    nmea_rmc_capture_if.slave  bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] IDX_FULL = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0] IDX_ONE  = (AW+1)'(1);
    localparam logic [AW:0] IDX_HDR_LAST = (AW+1)'(5);

    localparam logic [2:0] ST_HUNT = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_BODY = 3'd2;
    localparam logic [2:0] ST_CK1  = 3'd3;
    localparam logic [2:0] ST_CK2  = 3'd4;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;

    logic [2:0]    state_reg, state_next;
    logic [AW:0]   idx_reg, idx_next;
    logic [7:0]    chk_reg, chk_next;
    logic [3:0]    hi_reg, hi_next;
    logic          hi_ok_reg, hi_ok_next;
    logic          we_reg, we_next;
    logic [AW:0]   waddr_reg, waddr_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic          rd_bank_reg, rd_bank_next;
    logic [AW:0]   len_reg, len_next;
    logic          pend_reg, pend_next;
    logic [AW:0]   plen_reg, plen_next;
    logic          fv_reg, fv_next;
    logic          ck_reg, ck_next;
    logic          ov_reg, ov_next;

    logic          is_dollar;
    logic          frame_good;
    logic [4:0]    lo_dec;

    // Returns {valid, nibble}; only upper-case hex digits are accepted.
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46)
            r = {1'b1, 4'(c - 8'h37)};
        return r;
    endfunction

    function automatic logic [7:0] hdr_char(input logic [AW:0] i);
        logic [7:0] r;
        case (i)
            (AW+1)'(1): r = 8'h47;  // G
            (AW+1)'(2): r = 8'h50;  // P
            (AW+1)'(3): r = 8'h52;  // R
            (AW+1)'(4): r = 8'h4D;  // M
            (AW+1)'(5): r = 8'h43;  // C
            default:    r = 8'h00;
        endcase
        return r;
    endfunction

    assign is_dollar = bus.rx_valid && (bus.rx_data == CH_DOLLAR);
    assign lo_dec    = hex_val(bus.rx_data);

    // Byte-level parser: decides the write for this byte and the next parse state.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        chk_next   = chk_reg;
        hi_next    = hi_reg;
        hi_ok_next = hi_ok_reg;
        we_next    = 1'b0;
        waddr_next = {~rd_bank_reg, idx_reg[AW-1:0]};
        wdata_next = bus.rx_data;
        frame_good = 1'b0;
        ck_next    = 1'b0;
        ov_next    = 1'b0;

        if (is_dollar) begin
            // A '$' always restarts capture, discarding any partial sentence.
            we_next    = 1'b1;
            waddr_next = {~rd_bank_reg, {AW{1'b0}}};
            idx_next   = IDX_ONE;
            chk_next   = 8'h00;
            state_next = ST_HDR;
        end else if (bus.rx_valid) begin
            case (state_reg)
                ST_HDR: begin
                    if (bus.rx_data == hdr_char(idx_reg)) begin
                        we_next  = 1'b1;
                        chk_next = chk_reg ^ bus.rx_data;
                        idx_next = idx_reg + IDX_ONE;
                        if (idx_reg == IDX_HDR_LAST)
                            state_next = ST_BODY;
                    end else begin
                        state_next = ST_HUNT;
                    end
                end
                ST_BODY, ST_CK1, ST_CK2: begin
                    if (idx_reg == IDX_FULL) begin
                        ov_next    = 1'b1;
                        state_next = ST_HUNT;
                    end else begin
                        we_next  = 1'b1;
                        idx_next = idx_reg + IDX_ONE;
                        if (state_reg == ST_BODY) begin
                            if (bus.rx_data == CH_STAR)
                                state_next = ST_CK1;
                            else
                                chk_next = chk_reg ^ bus.rx_data;
                        end else if (state_reg == ST_CK1) begin
                            {hi_ok_next, hi_next} = hex_val(bus.rx_data);
                            state_next = ST_CK2;
                        end else begin
                            if (hi_ok_reg && lo_dec[4] && ({hi_reg, lo_dec[3:0]} == chk_reg))
                                frame_good = 1'b1;
                            else
                                ck_next = 1'b1;
                            state_next = ST_HUNT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bank arbitration: a good frame swaps immediately unless the reader holds its bank.
    always_comb begin
        rd_bank_next = rd_bank_reg;
        len_next     = len_reg;
        pend_next    = pend_reg;
        plen_next    = plen_reg;
        fv_next      = 1'b0;

        if (frame_good) begin
            if (!bus.rd_lock) begin
                rd_bank_next = ~rd_bank_reg;
                len_next     = idx_reg + IDX_ONE;
                fv_next      = 1'b1;
                pend_next    = 1'b0;
            end else begin
                pend_next = 1'b1;
                plen_next = idx_reg + IDX_ONE;
            end
        end else if (is_dollar) begin
            // The held sentence lives in the write bank, which is about to be overwritten.
            pend_next = 1'b0;
        end else if (pend_reg && !bus.rd_lock) begin
            rd_bank_next = ~rd_bank_reg;
            len_next     = plen_reg;
            fv_next      = 1'b1;
            pend_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_HUNT;
            idx_reg     <= '0;
            chk_reg     <= '0;
            hi_reg      <= '0;
            hi_ok_reg   <= 1'b0;
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            rd_bank_reg <= 1'b0;
            len_reg     <= '0;
            pend_reg    <= 1'b0;
            plen_reg    <= '0;
            fv_reg      <= 1'b0;
            ck_reg      <= 1'b0;
            ov_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            chk_reg     <= chk_next;
            hi_reg      <= hi_next;
            hi_ok_reg   <= hi_ok_next;
            we_reg      <= we_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
            rd_bank_reg <= rd_bank_next;
            len_reg     <= len_next;
            pend_reg    <= pend_next;
            plen_reg    <= plen_next;
            fv_reg      <= fv_next;
            ck_reg      <= ck_next;
            ov_reg      <= ov_next;
        end
    end

    assign bus.buf_we      = we_reg;
    assign bus.buf_waddr   = waddr_reg;
    assign bus.buf_wdata   = wdata_reg;
    assign bus.rd_bank     = rd_bank_reg;
    assign bus.frame_valid = fv_reg;
    assign bus.frame_len   = len_reg;
    assign bus.cksum_err   = ck_reg;
    assign bus.ovf_err     = ov_reg;
endmodule

// File: tb/tb_nmea_rmc_capture_ctrl.sv
// Bench for the RMC capture controller: directed sentences plus randomized streams,
// checked every cycle against a sentence-level queue model.
module tb_nmea_rmc_capture_ctrl;
    logic clk;
    logic rst_n;

    nmea_rmc_capture_if #(.AW(6)) bus_if ();

    nmea_rmc_capture_ctrl #(.BUF_DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the sentence collected since the last '$', plus the bank view.
    bit     m_active;
    byte    m_sent[$];
    bit     m_rdb;
    int     m_len;
    bit     m_pend;
    int     m_plen;
    bit     cur_lock;
    string  hdr = "$GPRMC";

    bit     exp_we, exp_fv, exp_ck, exp_ov;
    int     exp_addr;
    byte    exp_data;

    function automatic void hexv(input byte c, output bit ok, output int v);
        ok = 1'b0;
        v  = 0;
        if (c >= "0" && c <= "9") begin ok = 1'b1; v = c - "0"; end
        else if (c >= "A" && c <= "F") begin ok = 1'b1; v = c - "A" + 10; end
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_sent.delete();
        m_rdb  = 1'b0;
        m_len  = 0;
        m_pend = 1'b0;
        m_plen = 0;
    endtask

    task automatic model_step(input bit valid, input byte data, input bit lock);
        bit good;
        bit dollar;
        int n;
        int star;
        int x;
        int hv, lv;
        bit hok, lok;
        exp_we = 0; exp_fv = 0; exp_ck = 0; exp_ov = 0;
        good = 0;
        dollar = valid && (data == "$");
        if (dollar) begin
            m_active = 1'b1;
            m_sent.delete();
            m_sent.push_back(data);
            exp_we = 1; exp_addr = (m_rdb ? 0 : 64); exp_data = data;
        end else if (valid && m_active) begin
            n = m_sent.size();
            if (n < 6) begin
                if (data == hdr[n]) begin
                    exp_we = 1; exp_addr = (m_rdb ? 0 : 64) + n; exp_data = data;
                    m_sent.push_back(data);
                end else begin
                    m_active = 1'b0;
                end
            end else if (n >= 64) begin
                exp_ov = 1;
                m_active = 1'b0;
            end else begin
                exp_we = 1; exp_addr = (m_rdb ? 0 : 64) + n; exp_data = data;
                m_sent.push_back(data);
                star = -1;
                for (int i = 6; i < m_sent.size(); i++)
                    if (star < 0 && m_sent[i] == "*") star = i;
                if (star >= 0 && m_sent.size() == star + 3) begin
                    x = 0;
                    for (int i = 1; i < star; i++) x = x ^ int'(m_sent[i]);
                    hexv(m_sent[star+1], hok, hv);
                    hexv(m_sent[star+2], lok, lv);
                    if (hok && lok && (hv * 16 + lv) == x) good = 1;
                    else exp_ck = 1;
                    m_active = 1'b0;
                end
            end
        end
        if (good) begin
            if (!lock) begin
                m_rdb = ~m_rdb; m_len = m_sent.size(); exp_fv = 1;
            end else begin
                m_pend = 1'b1; m_plen = m_sent.size();
            end
        end else if (dollar) begin
            m_pend = 1'b0;
        end else if (m_pend && !lock) begin
            m_rdb = ~m_rdb; m_len = m_plen; exp_fv = 1; m_pend = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model, check every output just after the edge.
    task automatic cycle(input bit valid, input byte data);
        bus_if.rx_valid = valid;
        bus_if.rx_data  = data;
        bus_if.rd_lock  = cur_lock;
        model_step(valid, data, cur_lock);
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_if.buf_we !== exp_we) begin
            n_err++; $display("FAIL buf_we: got %b want %b", bus_if.buf_we, exp_we);
        end
        if (exp_we && bus_if.buf_waddr !== 7'(exp_addr)) begin
            n_err++; $display("FAIL buf_waddr: got %0d want %0d", bus_if.buf_waddr, exp_addr);
        end
        if (exp_we && bus_if.buf_wdata !== 8'(exp_data)) begin
            n_err++; $display("FAIL buf_wdata: got %h want %h", bus_if.buf_wdata, exp_data);
        end
        if (bus_if.rd_bank !== m_rdb) begin
            n_err++; $display("FAIL rd_bank: got %b want %b", bus_if.rd_bank, m_rdb);
        end
        if (bus_if.frame_valid !== exp_fv) begin
            n_err++; $display("FAIL frame_valid: got %b want %b", bus_if.frame_valid, exp_fv);
        end
        if (bus_if.frame_len !== 7'(m_len)) begin
            n_err++; $display("FAIL frame_len: got %0d want %0d", bus_if.frame_len, m_len);
        end
        if (bus_if.cksum_err !== exp_ck) begin
            n_err++; $display("FAIL cksum_err: got %b want %b", bus_if.cksum_err, exp_ck);
        end
        if (bus_if.ovf_err !== exp_ov) begin
            n_err++; $display("FAIL ovf_err: got %b want %b", bus_if.ovf_err, exp_ov);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic send_str(input string s);
        $display("tx \"%s\" lock=%0b", s, cur_lock);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if ({bus_if.buf_we, bus_if.buf_waddr, bus_if.buf_wdata, bus_if.rd_bank,
             bus_if.frame_valid, bus_if.frame_len, bus_if.cksum_err, bus_if.ovf_err} !== '0) begin
            n_err++;
            $display("FAIL %s: outputs not zero we=%b addr=%0d data=%h bank=%b fv=%b len=%0d ck=%b ov=%b",
                     tag, bus_if.buf_we, bus_if.buf_waddr, bus_if.buf_wdata, bus_if.rd_bank,
                     bus_if.frame_valid, bus_if.frame_len, bus_if.cksum_err, bus_if.ovf_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rd_lock  = 1'b0;
        cur_lock = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good_frame();
        send_str("$GPRMC,A*26");
        n_vec++;
        if (bus_if.frame_valid !== 1'b1 || bus_if.rd_bank !== 1'b1 || bus_if.frame_len !== 7'd11) begin
            n_err++;
            $display("FAIL good_frame: fv=%b bank=%b len=%0d want 1 1 11",
                     bus_if.frame_valid, bus_if.rd_bank, bus_if.frame_len);
        end
        idle(2);
    endtask

    task automatic test_bad_cksum();
        send_str("$GPRMC,A*27");
        n_vec++;
        if (bus_if.cksum_err !== 1'b1 || bus_if.rd_bank !== 1'b1 || bus_if.frame_len !== 7'd11) begin
            n_err++;
            $display("FAIL bad_cksum: ck=%b bank=%b len=%0d want 1 1 11",
                     bus_if.cksum_err, bus_if.rd_bank, bus_if.frame_len);
        end
        send_str("$GPRMC,A*2g");
        idle(2);
    endtask

    task automatic test_hdr_abort();
        send_str("$GPGGA,1*00");
        send_str("$GPRMC,A*26");
        n_vec++;
        if (bus_if.frame_valid !== 1'b1 || bus_if.rd_bank !== 1'b0) begin
            n_err++;
            $display("FAIL hdr_abort: fv=%b bank=%b want 1 0", bus_if.frame_valid, bus_if.rd_bank);
        end
        idle(2);
    endtask

    task automatic test_overflow();
        string s;
        s = "$GPRMC,";
        for (int i = 0; i < 60; i++) s = {s, "X"};
        send_str(s);
        send_str("$GPRMC,ABCDEFGHIJKLMNOPQRSTUVWXYZABCDEFGHIJKLMNOPQRSTUVWXYZ*00");
        idle(2);
    endtask

    task automatic test_rd_lock();
        bit bank0;
        bank0 = m_rdb;
        cur_lock = 1'b1;
        send_str("$GPRMC,A*26");
        idle(20);
        n_vec++;
        if (bus_if.rd_bank !== bank0) begin
            n_err++; $display("FAIL lock_hold: bank=%b want %b", bus_if.rd_bank, bank0);
        end
        cur_lock = 1'b0;
        idle(1);
        n_vec++;
        if (bus_if.frame_valid !== 1'b1 || bus_if.rd_bank === bank0) begin
            n_err++; $display("FAIL lock_release: fv=%b bank=%b want 1 %b",
                              bus_if.frame_valid, bus_if.rd_bank, ~bank0);
        end
        bank0 = m_rdb;
        cur_lock = 1'b1;
        send_str("$GPRMC,A*26");
        idle(3);
        send_str("$GP");
        cur_lock = 1'b0;
        idle(5);
        n_vec++;
        if (bus_if.rd_bank !== bank0) begin
            n_err++; $display("FAIL lock_cancel: bank=%b want %b", bus_if.rd_bank, bank0);
        end
        // '$' arriving in the very cycle the lock drops must cancel the pending swap.
        cur_lock = 1'b1;
        send_str("$GPRMC,A*26");
        cur_lock = 1'b0;
        send_str("$");
        idle(3);
    endtask

    task automatic test_reset_mid();
        send_str("$GPRMC,12345");
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_str("$GPRMC,A*26");
        n_vec++;
        if (bus_if.rd_bank !== 1'b1 || bus_if.frame_len !== 7'd11) begin
            n_err++; $display("FAIL reset_recover: bank=%b len=%0d want 1 11",
                              bus_if.rd_bank, bus_if.frame_len);
        end
        idle(2);
    endtask

    task automatic test_random();
        string s;
        int blen, x, r;
        byte c;
        for (int k = 0; k < 150; k++) begin
            s = ($urandom_range(0, 9) == 0) ? "$GPGGA," : "$GPRMC,";
            blen = $urandom_range(0, 60);
            for (int i = 0; i < blen; i++) begin
                do c = byte'($urandom_range(32, 126)); while (c == "$" || c == "*");
                s = $sformatf("%s%c", s, c);
            end
            x = 0;
            for (int i = 1; i < s.len(); i++) x = x ^ int'(s[i]);
            r = $urandom_range(0, 9);
            if (r == 0)      s = $sformatf("%s*%02X", s, (x ^ 1) & 8'hFF);
            else if (r == 1) s = $sformatf("%s*%02x", s, x | 8'hAA);
            else if (r == 2) s = $sformatf("%s*$G", s);
            else             s = $sformatf("%s*%02X", s, x);
            $display("tx \"%s\" lock=%0b", s, cur_lock);
            for (int i = 0; i < s.len(); i++) begin
                if ($urandom_range(0, 29) == 0) cur_lock = ~cur_lock;
                cycle(1'b1, s[i]);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) begin
                cur_lock = 1'b0;
                idle($urandom_range(1, 4));
            end
        end
        cur_lock = 1'b0;
        idle(4);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_cksum();
        test_hdr_abort();
        test_overflow();
        test_rd_lock();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
